// File: rtl/am2910_seq.sv
// Am2910-compatible microprogram sequencer: selects the next microcode address
// from microPC, register/counter R, the direct input D or the return stack.
module am2910_seq #(
    parameter int AW     = 12,
    parameter int SDEPTH = 5
) (
    input  logic          cp,
    input  logic          rst,
    input  logic [3:0]    i,
    input  logic          cc_n,
    input  logic          ccen_n,
    input  logic          ci,
    input  logic          rld_n,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] y,
    output logic          pl_n,
    output logic          map_n,
    output logic          vect_n,
    output logic          full_n
);

    localparam int SPW = $clog2(SDEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [AW-1:0]  A_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]  A_ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } instr_t;

    logic [AW-1:0]  upc_r;
    logic [AW-1:0]  r_r;
    logic [SPW-1:0] sp_r;
    logic [AW-1:0]  stack_r [SDEPTH];
    logic [AW-1:0]  last_wr_r;
    logic           full_n_r;

    instr_t         instr_s;
    logic           pass_s;
    logic           r_zero_s;
    logic [SPW-1:0] tos_idx_s;
    logic [SPW-1:0] push_idx_s;
    logic [SPW-1:0] sp_next_s;
    logic [AW-1:0]  tos_s;
    logic [AW-1:0]  y_s;
    logic           push_s;
    logic           pop_s;
    logic           clr_s;
    logic           r_dec_s;
    logic           r_ld_s;

    assign instr_s  = instr_t'(i);
    assign pass_s   = ccen_n | ~cc_n;
    assign r_zero_s = (r_r == A_ZERO);

    // Top-of-stack read; an empty stack still presents the most recently pushed value.
    always_comb begin
        tos_idx_s  = sp_r - SP_ONE;
        push_idx_s = sp_r;
        tos_s      = last_wr_r;
        if (sp_r == SP_FULL) begin
            push_idx_s = SP_FULL - SP_ONE;
        end else begin
            push_idx_s = sp_r;
        end
        if (sp_r != {SPW{1'b0}}) begin
            tos_s = stack_r[tos_idx_s];
        end else begin
            tos_s = last_wr_r;
        end
    end

    // Instruction decode: next address plus stack and R side effects.
    always_comb begin
        y_s     = upc_r;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        clr_s   = 1'b0;
        r_dec_s = 1'b0;
        r_ld_s  = 1'b0;
        case (instr_s)
            JZ: begin
                y_s   = A_ZERO;
                clr_s = 1'b1;
            end
            CJS: begin
                if (pass_s) begin
                    y_s    = d;
                    push_s = 1'b1;
                end else begin
                    y_s = upc_r;
                end
            end
            JMAP: y_s = d;
            CJP, CJV: begin
                if (pass_s) begin
                    y_s = d;
                end else begin
                    y_s = upc_r;
                end
            end
            PUSH: begin
                y_s    = upc_r;
                push_s = 1'b1;
                r_ld_s = pass_s;
            end
            JSRP: begin
                push_s = 1'b1;
                if (pass_s) begin
                    y_s = d;
                end else begin
                    y_s = r_r;
                end
            end
            JRP: begin
                if (pass_s) begin
                    y_s = d;
                end else begin
                    y_s = r_r;
                end
            end
            RFCT: begin
                if (!r_zero_s) begin
                    y_s     = tos_s;
                    r_dec_s = 1'b1;
                end else begin
                    y_s   = upc_r;
                    pop_s = 1'b1;
                end
            end
            RPCT: begin
                if (!r_zero_s) begin
                    y_s     = d;
                    r_dec_s = 1'b1;
                end else begin
                    y_s = upc_r;
                end
            end
            CRTN: begin
                if (pass_s) begin
                    y_s   = tos_s;
                    pop_s = 1'b1;
                end else begin
                    y_s = upc_r;
                end
            end
            CJPP: begin
                if (pass_s) begin
                    y_s   = d;
                    pop_s = 1'b1;
                end else begin
                    y_s = upc_r;
                end
            end
            LDCT: begin
                y_s    = upc_r;
                r_ld_s = 1'b1;
            end
            LOOP: begin
                if (pass_s) begin
                    y_s   = upc_r;
                    pop_s = 1'b1;
                end else begin
                    y_s = tos_s;
                end
            end
            CONT: y_s = upc_r;
            TWB: begin
                if (pass_s) begin
                    y_s   = upc_r;
                    pop_s = 1'b1;
                end else if (!r_zero_s) begin
                    y_s     = tos_s;
                    r_dec_s = 1'b1;
                end else begin
                    y_s   = d;
                    pop_s = 1'b1;
                end
            end
            default: y_s = upc_r;
        endcase
    end

    // Stack pointer update; a push on a full stack overwrites TOS without moving SP.
    always_comb begin
        sp_next_s = sp_r;
        if (clr_s) begin
            sp_next_s = {SPW{1'b0}};
        end else if (push_s) begin
            if (sp_r != SP_FULL) begin
                sp_next_s = sp_r + SP_ONE;
            end else begin
                sp_next_s = sp_r;
            end
        end else if (pop_s) begin
            if (sp_r != {SPW{1'b0}}) begin
                sp_next_s = sp_r - SP_ONE;
            end else begin
                sp_next_s = sp_r;
            end
        end else begin
            sp_next_s = sp_r;
        end
    end

    // Sequencer state: microPC, R, stack and the registered full flag.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            upc_r     <= A_ZERO;
            r_r       <= A_ZERO;
            sp_r      <= {SPW{1'b0}};
            last_wr_r <= A_ZERO;
            full_n_r  <= 1'b1;
            for (int k = 0; k < SDEPTH; k++) begin
                stack_r[k] <= A_ZERO;
            end
        end else begin
            upc_r    <= y_s + {{(AW-1){1'b0}}, ci};
            sp_r     <= sp_next_s;
            full_n_r <= (sp_next_s != SP_FULL);
            // An external load always wins over the counter decrement.
            if (!rld_n || r_ld_s) begin
                r_r <= d;
            end else if (r_dec_s) begin
                r_r <= r_r - A_ONE;
            end
            if (push_s) begin
                stack_r[push_idx_s] <= upc_r;
                last_wr_r           <= upc_r;
            end
        end
    end

    assign y      = y_s;
    assign map_n  = (i != 4'd2);
    assign vect_n = (i != 4'd6);
    assign pl_n   = (i == 4'd2) || (i == 4'd6);
    assign full_n = full_n_r;

endmodule
